// File: rtl/inst_axi_bridge.sv
// Instruction-fetch SRAM-like to AXI read bridge; keeps up to MAX_OUT AR requests in flight.
// Latency: addr_ok same cycle, arvalid next cycle; data_ok in the R handshake cycle (one cycle later with INST_BRIDGE_RBUF_EN).
// Backpressure: new fetches are refused while an AR is pending or the in-flight limit is reached; R is stalled only when nothing is outstanding (or the R buffer is full).
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   inst_sram_*                 SRAM-like fetch port from the IF stage (wstrb/wdata unused)
//   ar*                         AXI read-address channel (id/len/burst/lock/cache/prot constant)
//   r*                          AXI read-data channel (rid/rresp/rlast unused)
//
// Optional feature: define INST_BRIDGE_RBUF_EN to register the R beat in a one-entry buffer
// before presenting it as data_ok/rdata.
module inst_axi_bridge #(
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;

  localparam logic [2:0] MAX_OUT_W = 3'(MAX_OUT);

  ar_state_t   ar_state;
  logic [1:0]  out_cnt;     // AR done, R beat not yet received
  logic        ar_pending;
  logic        ar_done;
  logic        r_hs;
  logic        held;        // beat sitting in the R buffer (0 without the buffer)
  logic [2:0]  in_flight;
  logic        accept;
  logic        unused_inputs;

  assign arid    = 4'd0;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  // Payload fields the bridge never looks at.
  assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

  assign ar_pending = (ar_state == AR_BUSY);
  assign ar_done    = ar_pending && arready;
  assign r_hs       = rvalid && rready;

`ifdef INST_BRIDGE_RBUF_EN
  logic        rbuf_vld;
  logic [31:0] rbuf_dat;

  // Buffer accepts a beat only when empty, so it drains and refills on alternate cycles.
  assign rready            = !reset && (out_cnt != 2'd0) && !rbuf_vld;
  assign inst_sram_data_ok = !reset && rbuf_vld;
  assign inst_sram_rdata   = rbuf_dat;
  assign held              = rbuf_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      rbuf_vld <= 1'b0;
      rbuf_dat <= 32'd0;
    end else if (r_hs) begin
      rbuf_vld <= 1'b1;
      rbuf_dat <= rdata;
    end else if (rbuf_vld) begin
      rbuf_vld <= 1'b0;
    end
  end
`else
  assign rready            = !reset && (out_cnt != 2'd0);
  assign inst_sram_data_ok = r_hs;
  assign inst_sram_rdata   = rdata;
  assign held              = 1'b0;
`endif

  // Everything already committed to the IF stage counts against the limit.
  assign in_flight = {1'b0, out_cnt} + {2'b0, ar_pending} + {2'b0, held};

  assign accept = !reset && (ar_state == AR_IDLE) && inst_sram_req && !inst_sram_wr &&
                  (in_flight < MAX_OUT_W);

  assign inst_sram_addr_ok = accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state <= AR_IDLE;
      arvalid  <= 1'b0;
      araddr   <= 32'd0;
      arsize   <= 3'd0;
      out_cnt  <= 2'd0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (accept) begin
            ar_state <= AR_BUSY;
            arvalid  <= 1'b1;
            araddr   <= inst_sram_addr;
            arsize   <= {1'b0, inst_sram_size};
          end
        end
        AR_BUSY: begin
          if (arready) begin
            ar_state <= AR_IDLE;
            arvalid  <= 1'b0;
          end
        end
        default: begin
          ar_state <= AR_IDLE;
          arvalid  <= 1'b0;
        end
      endcase

      // Simultaneous AR completion and R handshake cancel out.
      case ({ar_done, r_hs})
        2'b10:   out_cnt <= out_cnt + 2'd1;
        2'b01:   out_cnt <= out_cnt - 2'd1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

endmodule
